// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares one byte-wide SDRAM controller port between three clients:
//   port 0 = CPU (ROM/cart RAM), port 1 = save-RAM backup engine,
//   port 2 = ROM loader. Client handshake is level req / one-cycle ack.
//   On the controller side, reads use an edge-triggered rd with a rd_rdy busy
//   flag, and writes use a we/we_ack toggle pair. Only one access is in flight.
//
// Ports
//   clk, reset            controller clock, synchronous active-high reset
//   cN_req/we/addr/din    client N request (level, held until cN_ack)
//   cN_ack                one-cycle completion pulse to client N
//   cN_dout               last read result for client N (0xFF after an abort)
//   mem_raddr, mem_rd     read address / read request (rising edge starts a read)
//   mem_rd_rdy, mem_dout  controller busy flag (0 = read in flight) / read data
//   mem_waddr, mem_din    write address / write data
//   mem_we, mem_we_ack    write toggle / controller's copy on completion
//   timeout               one-cycle pulse when an access is aborted
module sdram_port_arbiter #(
    parameter int AW      = 25,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c0_req,
    input  logic          c0_we,
    input  logic [AW-1:0] c0_addr,
    input  logic [7:0]    c0_din,
    output logic          c0_ack,
    output logic [7:0]    c0_dout,
    input  logic          c1_req,
    input  logic          c1_we,
    input  logic [AW-1:0] c1_addr,
    input  logic [7:0]    c1_din,
    output logic          c1_ack,
    output logic [7:0]    c1_dout,
    input  logic          c2_req,
    input  logic          c2_we,
    input  logic [AW-1:0] c2_addr,
    input  logic [7:0]    c2_din,
    output logic          c2_ack,
    output logic [7:0]    c2_dout,
    output logic [AW-1:0] mem_raddr,
    output logic          mem_rd,
    input  logic          mem_rd_rdy,
    input  logic [7:0]    mem_dout,
    output logic [AW-1:0] mem_waddr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    input  logic          mem_we_ack,
    output logic          timeout
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        DONE
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

    state_t        state;
    logic [1:0]    gnt;
    logic          rr;          // 0: port 1 preferred, 1: port 2 preferred
    logic [7:0]    wait_cnt;
    logic [2:0]    ack;
    logic [2:0]    req;

    logic [1:0]    pick;
    logic          pick_vld;
    logic [AW-1:0] pick_addr;
    logic [7:0]    pick_din;
    logic          pick_we;

    logic          in_wait;
    logic          rd_accepted;
    logic          finish_ok;
    logic          expired;
    logic          complete;
    logic          load_dout;
    logic [7:0]    rd_result;

    assign req    = {c2_req, c1_req, c0_req};
    assign c0_ack = ack[0];
    assign c1_ack = ack[1];
    assign c2_ack = ack[2];

    function automatic logic [2:0] port_mask(input logic [1:0] p);
        port_mask = 3'b000;
        case (p)
            2'd0:    port_mask = 3'b001;
            2'd1:    port_mask = 3'b010;
            2'd2:    port_mask = 3'b100;
            default: port_mask = 3'b000;
        endcase
    endfunction

    // Port 0 always wins; ports 1 and 2 share by the rr bit.
    always_comb begin
        pick_vld = |req;
        if (req[0]) begin
            pick = 2'd0;
        end else if (req[1] && (!req[2] || !rr)) begin
            pick = 2'd1;
        end else begin
            pick = 2'd2;
        end
    end

    always_comb begin
        case (pick)
            2'd1: begin
                pick_addr = c1_addr;
                pick_din  = c1_din;
                pick_we   = c1_we;
            end
            2'd2: begin
                pick_addr = c2_addr;
                pick_din  = c2_din;
                pick_we   = c2_we;
            end
            default: begin
                pick_addr = c0_addr;
                pick_din  = c0_din;
                pick_we   = c0_we;
            end
        endcase
    end

    // rd_rdy may still read 1 when RD_ISSUE is entered, so a read only
    // completes after the controller has been seen busy (RD_WAIT).
    always_comb begin
        in_wait     = (state == RD_ISSUE) || (state == RD_WAIT) || (state == WR_WAIT);
        rd_accepted = (state == RD_ISSUE) && !mem_rd_rdy;
        finish_ok   = ((state == RD_WAIT) && mem_rd_rdy) ||
                      ((state == WR_WAIT) && (mem_we_ack == mem_we));
        expired     = in_wait && !rd_accepted && !finish_ok && (wait_cnt == WAIT_LIMIT);
        complete    = finish_ok || expired;
        load_dout   = ((state == RD_WAIT) && finish_ok) ||
                      (expired && (state != WR_WAIT));
        rd_result   = expired ? 8'hFF : mem_dout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= 2'd0;
            rr       <= 1'b0;
            wait_cnt <= 8'd0;
            ack      <= 3'b000;
            mem_rd   <= 1'b0;
            mem_we   <= mem_we_ack;   // withdraw a write the controller has not taken
            timeout  <= 1'b0;
        end else begin
            ack     <= complete ? port_mask(gnt) : 3'b000;
            timeout <= expired;
            if (expired) begin
                mem_rd   <= 1'b0;
                mem_we   <= mem_we_ack;
                state    <= DONE;
                wait_cnt <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        wait_cnt <= 8'd0;
                        if (pick_vld) begin
                            gnt       <= pick;
                            mem_raddr <= pick_addr;
                            mem_waddr <= pick_addr;
                            mem_din   <= pick_din;
                            if (pick != 2'd0) begin
                                rr <= (pick == 2'd1);
                            end
                            if (pick_we) begin
                                state <= WR_ISSUE;
                            end else begin
                                state  <= RD_ISSUE;
                                mem_rd <= 1'b1;
                            end
                        end
                    end
                    RD_ISSUE: begin
                        if (rd_accepted) begin
                            mem_rd   <= 1'b0;
                            state    <= RD_WAIT;
                            wait_cnt <= 8'd0;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                    RD_WAIT, WR_WAIT: begin
                        if (finish_ok) begin
                            state    <= DONE;
                            wait_cnt <= 8'd0;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                    WR_ISSUE: begin
                        mem_we   <= ~mem_we;
                        state    <= WR_WAIT;
                        wait_cnt <= 8'd0;
                    end
                    DONE: begin
                        state    <= IDLE;
                        wait_cnt <= 8'd0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Read results stay put until the next read for the same port.
    always_ff @(posedge clk) begin
        if (reset) begin
            c0_dout <= 8'h00;
            c1_dout <= 8'h00;
            c2_dout <= 8'h00;
        end else if (load_dout) begin
            if (gnt == 2'd0) c0_dout <= rd_result;
            if (gnt == 2'd1) c1_dout <= rd_result;
            if (gnt == 2'd2) c2_dout <= rd_result;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
//   Testbench for sdram_port_arbiter: a behavioural SDRAM controller with a
//   16-byte store (indexed by addr[3:0]), a client-level reference memory and
//   a grant-order model built from the arbitration rules.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    req;
    logic [2:0]    we_c;
    logic [AW-1:0] addr_c [3];
    logic [7:0]    din_c [3];
    logic          c0_ack, c1_ack, c2_ack;
    logic [7:0]    c0_dout, c1_dout, c2_dout;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic          mem_rd, mem_rd_rdy, mem_we, mem_we_ack, timeout;
    logic [7:0]    mem_dout, mem_din;

    sdram_port_arbiter #(.AW(AW), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .c0_req(req[0]), .c0_we(we_c[0]), .c0_addr(addr_c[0]), .c0_din(din_c[0]),
        .c0_ack(c0_ack), .c0_dout(c0_dout),
        .c1_req(req[1]), .c1_we(we_c[1]), .c1_addr(addr_c[1]), .c1_din(din_c[1]),
        .c1_ack(c1_ack), .c1_dout(c1_dout),
        .c2_req(req[2]), .c2_we(we_c[2]), .c2_addr(addr_c[2]), .c2_din(din_c[2]),
        .c2_ack(c2_ack), .c2_dout(c2_dout),
        .mem_raddr(mem_raddr), .mem_rd(mem_rd), .mem_rd_rdy(mem_rd_rdy), .mem_dout(mem_dout),
        .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_we(mem_we), .mem_we_ack(mem_we_ack),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Controller model
    logic          ctrl_init, rd_stall, wr_stall;
    logic [7:0]    ram [16];
    logic          mem_rd_q, rd_busy;
    int            rd_cnt, wr_cnt, wr_done;
    logic [AW-1:0] rd_addr_l, last_raddr, last_waddr;
    logic [7:0]    last_wdin;

    always @(posedge clk) begin
        if (ctrl_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'hA0 + 8'(i);
            mem_rd_q   <= 1'b0;
            rd_busy    <= 1'b0;
            rd_cnt     <= 0;
            wr_cnt     <= 0;
            wr_done    <= 0;
            mem_rd_rdy <= 1'b1;
            mem_dout   <= 8'h00;
            mem_we_ack <= 1'b0;
        end else begin
            mem_rd_q <= mem_rd;
            if (rd_busy) begin
                if (rd_cnt == 0) begin
                    mem_dout   <= ram[rd_addr_l[3:0]];
                    mem_rd_rdy <= 1'b1;
                    rd_busy    <= 1'b0;
                end else begin
                    rd_cnt <= rd_cnt - 1;
                end
            end else if (mem_rd && !mem_rd_q && !rd_stall) begin
                mem_rd_rdy <= 1'b0;
                rd_busy    <= 1'b1;
                rd_addr_l  <= mem_raddr;
                last_raddr <= mem_raddr;
                rd_cnt     <= int'($urandom_range(0, 4));
            end
            if ((mem_we !== mem_we_ack) && !wr_stall) begin
                if (wr_cnt == 0) begin
                    ram[mem_waddr[3:0]] <= mem_din;
                    last_waddr <= mem_waddr;
                    last_wdin  <= mem_din;
                    mem_we_ack <= mem_we;
                    wr_done    <= wr_done + 1;
                    wr_cnt     <= int'($urandom_range(0, 3));
                end else begin
                    wr_cnt <= wr_cnt - 1;
                end
            end
        end
    end

    // Bench state
    int         n_cmp = 0;
    int         n_fail = 0;
    int         ack_cnt [3];
    int         to_cnt, rd_rises, we_toggles, pref;
    logic       rd_prev, we_prev;
    logic [7:0] ref_mem [16];

    function automatic logic ack_of(input int p);
        case (p)
            0:       return c0_ack;
            1:       return c1_ack;
            default: return c2_ack;
        endcase
    endfunction

    function automatic logic [7:0] dout_of(input int p);
        case (p)
            0:       return c0_dout;
            1:       return c1_dout;
            default: return c2_dout;
        endcase
    endfunction

    // Expected winner from the pending set: port 0 first, otherwise the
    // preferred one of ports 1/2 when both wait.
    function automatic int model_pick(input logic [2:0] r);
        if (r[0]) return 0;
        if (r[1] && r[2]) return pref;
        if (r[1]) return 1;
        if (r[2]) return 2;
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
        for (int p = 0; p < 3; p++) if (ack_of(p)) ack_cnt[p]++;
        if (timeout) to_cnt++;
        if (mem_rd && !rd_prev) rd_rises++;
        if (mem_we !== we_prev) we_toggles++;
        rd_prev = mem_rd;
        we_prev = mem_we;
    endtask

    task automatic wait_ack(input int limit, output int port, output int n_acks, output int cycles);
        port = -1; n_acks = 0; cycles = 0;
        while (n_acks == 0 && cycles < limit) begin
            step();
            cycles++;
            for (int p = 0; p < 3; p++) begin
                if (ack_of(p)) begin
                    n_acks++;
                    port = p;
                end
            end
        end
    endtask

    task automatic do_reset();
        req = 3'b000;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        ctrl_init = 1'b0;
        pref = 1;
        rd_prev = mem_rd;
        we_prev = mem_we;
    endtask

    task automatic new_op(input int p);
        we_c[p]   = 1'($urandom_range(0, 1));
        addr_c[p] = AW'($urandom);
        din_c[p]  = 8'($urandom);
        req[p]    = 1'b1;
    endtask

    task automatic test_reset();
        ctrl_init = 1'b1;
        do_reset();
        step();
        n_cmp++; if ({c2_ack, c1_ack, c0_ack} !== 3'b000) begin n_fail++; $display("FAIL reset_ack: got %b expected 000", {c2_ack, c1_ack, c0_ack}); end
        n_cmp++; if (c0_dout !== 8'h00) begin n_fail++; $display("FAIL reset_c0_dout: got %h expected 00", c0_dout); end
        n_cmp++; if (c1_dout !== 8'h00) begin n_fail++; $display("FAIL reset_c1_dout: got %h expected 00", c1_dout); end
        n_cmp++; if (c2_dout !== 8'h00) begin n_fail++; $display("FAIL reset_c2_dout: got %h expected 00", c2_dout); end
        n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
        n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        n_cmp++; if (mem_we !== mem_we_ack) begin n_fail++; $display("FAIL reset_mem_we: got %b expected %b", mem_we, mem_we_ack); end
    endtask

    task automatic test_single_read();
        int port, n, cy, r0, a0;
        addr_c[0] = 25'h0001235; we_c[0] = 1'b0; din_c[0] = 8'h00;
        r0 = rd_rises; a0 = ack_cnt[0];
        req[0] = 1'b1;
        wait_ack(60, port, n, cy);
        req[0] = 1'b0;
        n_cmp++; if (port !== 0 || n !== 1) begin n_fail++; $display("FAIL read_grant: got port %0d acks %0d expected port 0 acks 1", port, n); end
        n_cmp++; if (c0_dout !== 8'hA5) begin n_fail++; $display("FAIL read_data: got %h expected a5", c0_dout); end
        n_cmp++; if (last_raddr !== 25'h0001235) begin n_fail++; $display("FAIL read_addr: got %h expected 0001235", last_raddr); end
        step();
        n_cmp++; if (c0_ack !== 1'b0) begin n_fail++; $display("FAIL read_ack_pulse: got %b expected 0", c0_ack); end
        repeat (3) step();
        n_cmp++; if (rd_rises - r0 !== 1) begin n_fail++; $display("FAIL read_rd_pulses: got %0d expected 1", rd_rises - r0); end
        n_cmp++; if (ack_cnt[0] - a0 !== 1) begin n_fail++; $display("FAIL read_ack_count: got %0d expected 1", ack_cnt[0] - a0); end
    endtask

    task automatic test_write();
        int port, n, cy, w0;
        addr_c[1] = 25'h0400000; we_c[1] = 1'b1; din_c[1] = 8'h5A;
        w0 = we_toggles;
        req[1] = 1'b1;
        wait_ack(60, port, n, cy);
        req[1] = 1'b0;
        n_cmp++; if (port !== 1 || n !== 1) begin n_fail++; $display("FAIL write_grant: got port %0d acks %0d expected port 1 acks 1", port, n); end
        n_cmp++; if (last_waddr !== 25'h0400000) begin n_fail++; $display("FAIL write_addr: got %h expected 0400000", last_waddr); end
        n_cmp++; if (last_wdin !== 8'h5A) begin n_fail++; $display("FAIL write_data: got %h expected 5a", last_wdin); end
        n_cmp++; if (mem_we !== mem_we_ack) begin n_fail++; $display("FAIL write_toggle_match: got %b expected %b", mem_we, mem_we_ack); end
        ref_mem[0] = 8'h5A;
        repeat (3) step();
        n_cmp++; if (we_toggles - w0 !== 1) begin n_fail++; $display("FAIL write_toggles: got %0d expected 1", we_toggles - w0); end
    endtask

    task automatic run_traffic(input int n_ops, input bit rnd);
        int left [3];
        int exp_p, port, n, cy, r0, w0;
        for (int p = 0; p < 3; p++) left[p] = n_ops;
        while (left[0] + left[1] + left[2] > 0) begin
            if (req == 3'b000) begin
                for (int p = 0; p < 3; p++)
                    if (left[p] > 0 && (!rnd || $urandom_range(0, 1) == 1)) new_op(p);
                for (int p = 0; p < 3; p++)
                    if (req == 3'b000 && left[p] > 0) new_op(p);
            end
            exp_p = model_pick(req);
            r0 = rd_rises; w0 = we_toggles;
            wait_ack(100, port, n, cy);
            n_cmp++;
            if (n !== 1 || port !== exp_p) begin
                n_fail++;
                $display("FAIL grant_order: got port %0d acks %0d expected port %0d (req %b)", port, n, exp_p, req);
            end
            if (port < 0) begin
                req = 3'b000;
                repeat (5) step();
                return;
            end
            if (we_c[port]) begin
                n_cmp++; if (last_waddr !== addr_c[port] || last_wdin !== din_c[port]) begin n_fail++; $display("FAIL traffic_write p%0d: got %h/%h expected %h/%h", port, last_waddr, last_wdin, addr_c[port], din_c[port]); end
                n_cmp++; if (we_toggles - w0 !== 1 || rd_rises - r0 !== 0) begin n_fail++; $display("FAIL traffic_write_strobes p%0d: got we %0d rd %0d expected we 1 rd 0", port, we_toggles - w0, rd_rises - r0); end
                ref_mem[addr_c[port][3:0]] = din_c[port];
            end else begin
                n_cmp++; if (dout_of(port) !== ref_mem[addr_c[port][3:0]]) begin n_fail++; $display("FAIL traffic_read_data p%0d: got %h expected %h", port, dout_of(port), ref_mem[addr_c[port][3:0]]); end
                n_cmp++; if (last_raddr !== addr_c[port]) begin n_fail++; $display("FAIL traffic_read_addr p%0d: got %h expected %h", port, last_raddr, addr_c[port]); end
                n_cmp++; if (rd_rises - r0 !== 1 || we_toggles - w0 !== 0) begin n_fail++; $display("FAIL traffic_read_strobes p%0d: got rd %0d we %0d expected rd 1 we 0", port, rd_rises - r0, we_toggles - w0); end
            end
            if (port != 0) pref = 3 - port;
            left[port]--;
            if (left[port] > 0 && rnd && $urandom_range(0, 1) == 1) new_op(port);
            else req[port] = 1'b0;
            if (rnd) begin
                for (int p = 0; p < 3; p++)
                    if (p != port && !req[p] && left[p] > 0 && $urandom_range(0, 2) == 0) new_op(p);
            end
        end
        repeat (2) step();
    endtask

    task automatic test_arbitration();
        do_reset();
        run_traffic(2, 1'b0);
    endtask

    task automatic test_random_traffic();
        run_traffic(15, 1'b1);
    endtask

    task automatic test_timeout();
        int port, n, cy, t0;
        rd_stall = 1'b1;
        addr_c[2] = AW'($urandom); we_c[2] = 1'b0; din_c[2] = 8'h00;
        t0 = to_cnt;
        req[2] = 1'b1;
        wait_ack(400, port, n, cy);
        n_cmp++; if (port !== 2 || n !== 1) begin n_fail++; $display("FAIL timeout_grant: got port %0d acks %0d expected port 2 acks 1", port, n); end
        n_cmp++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse: got %b expected 1", timeout); end
        n_cmp++; if (c2_dout !== 8'hFF) begin n_fail++; $display("FAIL timeout_dout: got %h expected ff", c2_dout); end
        n_cmp++; if (cy < 250 || cy > 262) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected 250..262", cy); end
        n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL timeout_mem_rd: got %b expected 0", mem_rd); end
        req[2] = 1'b0;
        rd_stall = 1'b0;
        step();
        n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_one_cycle: got %b expected 0", timeout); end
        repeat (2) step();
        n_cmp++; if (to_cnt - t0 !== 1) begin n_fail++; $display("FAIL timeout_count: got %0d expected 1", to_cnt - t0); end
    endtask

    task automatic test_reset_during_write();
        int port, n, cy, w0, a0, guard;
        bit pending;
        wr_stall = 1'b1;
        addr_c[1] = {21'h0ABCD, 4'h3}; we_c[1] = 1'b1; din_c[1] = ~ref_mem[3];
        w0 = wr_done; a0 = ack_cnt[1];
        req[1] = 1'b1;
        pending = 1'b0; guard = 0;
        while (!pending && guard < 20) begin
            step();
            guard++;
            if (mem_we !== mem_we_ack) pending = 1'b1;
        end
        n_cmp++; if (pending !== 1'b1) begin n_fail++; $display("FAIL rstwr_pending: got %b expected 1", pending); end
        reset = 1'b1;
        req[1] = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        pref = 1;
        n_cmp++; if (mem_we !== mem_we_ack) begin n_fail++; $display("FAIL rstwr_cancel: got %b expected %b", mem_we, mem_we_ack); end
        wr_stall = 1'b0;
        repeat (10) step();
        n_cmp++; if (wr_done !== w0) begin n_fail++; $display("FAIL rstwr_no_write: got %0d expected %0d", wr_done, w0); end
        n_cmp++; if (ack_cnt[1] !== a0) begin n_fail++; $display("FAIL rstwr_no_ack: got %0d expected %0d", ack_cnt[1], a0); end
        we_c[1] = 1'b0;
        req[1] = 1'b1;
        wait_ack(60, port, n, cy);
        req[1] = 1'b0;
        n_cmp++; if (port !== 1 || c1_dout !== ref_mem[3]) begin n_fail++; $display("FAIL rstwr_readback: got port %0d data %h expected port 1 data %h", port, c1_dout, ref_mem[3]); end
        repeat (2) step();
    endtask

    task automatic test_back_to_back();
        int port, n, cy1, cy2, r0, a0;
        logic [7:0] exp1, exp2;
        addr_c[0] = {21'h1F00F, 4'h7}; we_c[0] = 1'b0;
        exp1 = ref_mem[7]; exp2 = ref_mem[9];
        r0 = rd_rises; a0 = ack_cnt[0];
        req[0] = 1'b1;
        wait_ack(60, port, n, cy1);
        n_cmp++; if (port !== 0 || c0_dout !== exp1) begin n_fail++; $display("FAIL b2b_first: got port %0d data %h expected port 0 data %h", port, c0_dout, exp1); end
        addr_c[0] = {21'h00123, 4'h9};
        wait_ack(60, port, n, cy2);
        req[0] = 1'b0;
        n_cmp++; if (port !== 0 || c0_dout !== exp2) begin n_fail++; $display("FAIL b2b_second: got port %0d data %h expected port 0 data %h", port, c0_dout, exp2); end
        n_cmp++; if (last_raddr !== {21'h00123, 4'h9}) begin n_fail++; $display("FAIL b2b_addr: got %h expected %h", last_raddr, {21'h00123, 4'h9}); end
        n_cmp++; if (cy2 < 3) begin n_fail++; $display("FAIL b2b_gap: got %0d cycles expected >= 3", cy2); end
        repeat (3) step();
        n_cmp++; if (ack_cnt[0] - a0 !== 2 || rd_rises - r0 !== 2) begin n_fail++; $display("FAIL b2b_counts: got acks %0d rd %0d expected 2 and 2", ack_cnt[0] - a0, rd_rises - r0); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ctrl_init = 1'b1; rd_stall = 1'b0; wr_stall = 1'b0;
        req = 3'b000; we_c = 3'b000;
        for (int p = 0; p < 3; p++) begin
            addr_c[p] = '0; din_c[p] = 8'h00; ack_cnt[p] = 0;
        end
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'hA0 + 8'(i);
        to_cnt = 0; rd_rises = 0; we_toggles = 0; pref = 1;
        rd_prev = 1'b0; we_prev = 1'b0;

        test_reset();
        test_single_read();
        test_write();
        test_arbitration();
        test_random_traffic();
        test_timeout();
        test_reset_during_write();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
